// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencing controller: widths, feedback
// mask, reset seed, command opcodes, FSM state encoding and the LFSR
// next-state function.
package lfsr_pkg;

    localparam int LFSR_W = 6;
    localparam int CNT_W  = 6;

    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 6'b110101;
    localparam logic [LFSR_W-1:0] LFSR_RST_SEED = 6'b111111;

    localparam logic OP_STEP = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Galois step: shift left, fold the taps in when the MSB falls out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], 1'b0} ^ (v[LFSR_W-1] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Command/response bus of the LFSR sequencing controller.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The source holds valid and its
// payload stable until that edge; ready may change freely.
interface lfsr_seq_ctrl_if;
    import lfsr_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [CNT_W-1:0]  cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [LFSR_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/lfsr_core.sv
// 6-bit Galois LFSR register. ld has priority over en; with neither the
// register holds. Asynchronous active-high reset to the reset seed.
module lfsr_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ld,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] lfsr_q
);

    logic [LFSR_W-1:0] lfsr_d;

    // Select load, step or hold for the next register value.
    always_comb begin
        lfsr_d = lfsr_q;
        if (ld) begin
            lfsr_d = seed;
        end else if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_RST_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven LFSR sequencer: LOAD writes a seed, STEP N advances the
// LFSR exactly N times, and each command returns the resulting LFSR state
// on the response channel. The LFSR is frozen while a response waits.
// Optional macro LFSR_LOCKUP_GUARD_EN: a zero seed is replaced by the
// reset seed and flagged on the sticky lockup_fix output.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    lfsr_seq_ctrl_if.slave       bus,
    output logic                 busy,
    output logic [LFSR_W-1:0]    lfsr_q,
`ifdef LFSR_LOCKUP_GUARD_EN
    output logic                 lockup_fix,
`endif
    output state_t               state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              core_en;
    logic              core_ld;
    logic [LFSR_W-1:0] core_seed;
    logic              cmd_fire;
`ifdef LFSR_LOCKUP_GUARD_EN
    logic              lockup_q, lockup_d;
`endif

    lfsr_core u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (core_en),
        .ld     (core_ld),
        .seed   (core_seed),
        .lfsr_q (lfsr_q)
    );

    // Ready only in IDLE and never while reset is asserted.
    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = lfsr_q;
    assign busy          = (state_q == RUN) || (state_q == RESP);
    assign state_dbg     = state_q;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
`ifdef LFSR_LOCKUP_GUARD_EN
    assign lockup_fix    = lockup_q;
`endif

    // Next-state, step counter and LFSR control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        core_en   = 1'b0;
        core_ld   = 1'b0;
        core_seed = bus.cmd_data;
`ifdef LFSR_LOCKUP_GUARD_EN
        lockup_d  = lockup_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (bus.cmd_op == OP_LOAD) begin
                        core_ld = 1'b1;
                        state_d = RESP;
`ifdef LFSR_LOCKUP_GUARD_EN
                        if (bus.cmd_data == '0) begin
                            core_seed = LFSR_RST_SEED;
                            lockup_d  = 1'b1;
                        end else begin
                            lockup_d  = 1'b0;
                        end
`endif
                    end else if (bus.cmd_data == '0) begin
                        // STEP 0 just reads the current state back.
                        state_d = RESP;
                    end else begin
                        cnt_d   = bus.cmd_data;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                core_en = 1'b1;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counter and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
`ifdef LFSR_LOCKUP_GUARD_EN
            lockup_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef LFSR_LOCKUP_GUARD_EN
            lockup_q <= lockup_d;
`endif
        end
    end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Command-driven controller that owns a 6-bit Galois LFSR register and sequences it: loads seeds, advances it a requested number of steps, and returns the resulting state.
Commands use a valid/ready handshake and responses use a valid/ready handshake.
Sits between a host/test sequencer and the pseudo-random source, so that stepping is explicit and counted rather than free-running.

Parameters:
W, 6, LFSR width in bits
TAPS, 6'b110101, Galois feedback mask applied when the MSB shifts out
RST_SEED, 6'b111111, LFSR value after reset
CNT_W, 6, width of the step-count field; maximum request is 2^CNT_W-1 steps

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  1  0 = STEP, 1 = LOAD
cmd_data  in  W (=CNT_W)  step count N (STEP) or seed (LOAD)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  W  LFSR state after the command
busy  out  1  high in RUN or RESP
lfsr_q  out  W  live LFSR register

Behaviour:
- Reset (async, rst=1): state=IDLE, lfsr=RST_SEED, cnt=0, rsp_valid=0, busy=0, cmd_ready=0 while rst is high; cmd_ready=1 from the first cycle after release.
- Next-state function: next = {lfsr[W-2:0],1'b0} ^ (lfsr[W-1] ? TAPS : 0).
- The FSM has three states: IDLE, RUN and RESP. cmd_ready = (state==IDLE), so a command is accepted on an edge with cmd_valid & cmd_ready. No other command is in flight at that point.
- IDLE, LOAD accepted: lfsr<=cmd_data, state<=RESP. rsp_data equals the seed in the next cycle.
- IDLE, STEP with N=0 accepted: lfsr unchanged, state<=RESP. This reads the current state.
- IDLE, STEP with N>0 accepted: cnt<=N, state<=RUN.
- RUN, each edge: lfsr<=next, cnt<=cnt-1. When cnt==1, state<=RESP.
- STEP latency: with acceptance on edge E0, exactly N steps occur on edges E1..EN, and rsp_valid is high from EN.
- RESP: rsp_valid=1 and rsp_data=lfsr, held stable and the LFSR frozen until rsp_ready=1. On that edge the FSM returns to IDLE. rsp_ready is ignored outside RESP.
- Back-to-back: the earliest next acceptance is the edge after the response handshake. Throughput is at most one command per N+2 cycles.
- rsp_ready tied high: RESP lasts exactly one cycle.
- Reset mid-RUN or mid-RESP: the operation is aborted, everything goes to reset values, and no response is issued.
- Zero state is a fixed point of next(). Loading 0 without the guard keeps the LFSR at 0 for all steps.

Optional Feature:
Macro LFSR_LOCKUP_GUARD_EN.
- Defined: a LOAD with cmd_data==0 writes RST_SEED instead of 0. A sticky output port lockup_fix (1 bit, reset 0) sets on that event and clears on the next accepted LOAD with a non-zero seed.
- Undefined: the seed is loaded verbatim, and the lockup_fix port does not exist.

Decomposition:
- Shared package lfsr_pkg holds LFSR_W=6, LFSR_TAPS=6'b110101, LFSR_RST_SEED=6'b111111, and the state encoding localparams (IDLE=2'd0, RUN=2'd1, RESP=2'd2).
- Sub-module lfsr_core: register with en, ld and seed inputs plus the next-state logic, with async active-high reset to RST_SEED.
- lfsr_seq_ctrl holds the FSM, the counter and the handshake, and instantiates lfsr_core.

Test Plan:
- Reset then read: release rst, issue STEP N=0 -> rsp_data=6'b111111 one cycle after acceptance. Check cmd_ready=0 and busy=1 during RESP.
- Step from reset: STEP N=1 -> rsp_data=6'b001011 after 1 edge. A fresh reset followed by STEP N=2 -> 6'b010110, with rsp_valid rising exactly on edge E2.
- Load then step: LOAD 6'b100000 -> rsp 6'b100000. STEP N=1 -> 6'b110101.
- Backpressure: STEP N=3 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, lfsr_q frozen, cmd_valid held high but not accepted. Raise rsp_ready -> IDLE, then the next command is accepted on the following edge.
- Reset mid-run: STEP N=40, assert rst at cycle 10 -> rsp_valid=0 immediately, lfsr_q=6'b111111, no response after release.
- Zero seed: LOAD 0 then STEP N=5 -> rsp_data=0 when the guard is off. With LFSR_LOCKUP_GUARD_EN, the LOAD rsp is 6'b111111 and lockup_fix=1.
